// File: rtl/jk_mod_counter_pkg.sv
// rtl/jk_mod_counter_pkg.sv - shared types and helpers for the JK modulo counter
package jk_pkg;

    localparam int CNT_W_PAD = 1;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    // One guard bit so MODULO = 2**WIDTH still fits the compare constants.
    function automatic int cnt_w(input int width);
        return width + CNT_W_PAD;
    endfunction

    // Set/reset-only excitation: {j,k}; never drives the 1/1 toggle code.
    function automatic logic [1:0] jk_excite(input logic q_bit, input logic n_bit);
        return {~q_bit & n_bit, q_bit & ~n_bit};
    endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// rtl/jk_mod_counter_if.sv - control/status bundle; JKCNT_GRAY_OUT_EN adds gray
interface jk_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tc;
    logic             load_err;
`ifdef JKCNT_GRAY_OUT_EN
    logic [WIDTH-1:0] gray;

    modport master (
        output en, up_dn, load, din,
        input  q, qbar, tc, load_err, gray
    );
    modport slave (
        input  en, up_dn, load, din,
        output q, qbar, tc, load_err, gray
    );
`else
    modport master (
        output en, up_dn, load, din,
        input  q, qbar, tc, load_err
    );
    modport slave (
        input  en, up_dn, load, din,
        output q, qbar, tc, load_err
    );
`endif
endinterface

// File: rtl/jk_mod_counter_cell.sv
// rtl/jk_mod_counter_cell.sv - single JK flip-flop with async active-low clear
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b10:   q <= 1'b1;
                2'b01:   q <= 1'b0;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - modulo-N up/down counter on a JK cell bank
// Optional registered Gray output when JKCNT_GRAY_OUT_EN is defined.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 10
) (
    input  logic          clk,
    input  logic          rst,
    jk_mod_counter_if.slave bus
);

    localparam int             CW    = cnt_w(WIDTH);
    localparam logic [CW-1:0]  MOD_V = CW'(MODULO);
    localparam logic [CW-1:0]  LAST  = CW'(MODULO - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [CW-1:0]    q_ext;
    logic [CW-1:0]    din_ext;
    logic             tc_d;
    logic             err_d;
    logic             tc_r;
    logic             err_r;
    dir_t             dir;

    assign q_ext   = {1'b0, q};
    assign din_ext = {1'b0, bus.din};
    assign dir     = dir_t'(bus.up_dn);

    always_comb begin
        nxt   = q;
        tc_d  = 1'b0;
        err_d = 1'b0;
        if (bus.load) begin
            if (din_ext < MOD_V) begin
                nxt = bus.din;
            end else begin
                nxt   = '0;
                err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (dir == DIR_UP) begin
                if (q_ext == LAST) begin
                    nxt  = '0;
                    tc_d = 1'b1;
                end else begin
                    nxt = WIDTH'(q_ext + CW'(1));
                end
            end else begin
                if (q_ext == '0) begin
                    nxt  = WIDTH'(LAST);
                    tc_d = 1'b1;
                end else begin
                    nxt = WIDTH'(q_ext - CW'(1));
                end
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign {j[i], k[i]} = jk_excite(q[i], nxt[i]);

        jk_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .j    (j[i]),
            .k    (k[i]),
            .q    (q[i]),
            .qbar (qbar[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tc_r  <= 1'b0;
            err_r <= 1'b0;
        end else begin
            tc_r  <= tc_d;
            err_r <= err_d;
        end
    end

`ifdef JKCNT_GRAY_OUT_EN
    logic [WIDTH-1:0] gray_r;

    // Encoded from the next count so it lands on the same edge as q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gray_r <= '0;
        end else begin
            gray_r <= nxt ^ (nxt >> 1);
        end
    end

    assign bus.gray = gray_r;
`endif

    assign bus.q        = q;
    assign bus.qbar     = qbar;
    assign bus.tc       = tc_r;
    assign bus.load_err = err_r;

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - self-checking bench for jk_mod_counter
module tb_jk_mod_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    jk_mod_counter_if #(.WIDTH(W)) bus ();
    jk_mod_counter_if #(.WIDTH(W)) bus16 ();

    jk_mod_counter #(.WIDTH(W), .MODULO(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    jk_mod_counter #(.WIDTH(W), .MODULO(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    typedef struct {
        logic       en;
        logic       up_dn;
        logic       load;
        logic [3:0] din;
        int         exp_q;
        logic       exp_tc;
        logic       exp_err;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    int   m_q   = 0;
    logic m_tc  = 1'b0;
    logic m_err = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q   = 0;
        m_tc  = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic u, input logic l, input int d);
        if (l) begin
            m_tc = 1'b0;
            if (d < M) begin
                m_q   = d;
                m_err = 1'b0;
            end else begin
                m_q   = 0;
                m_err = 1'b1;
            end
        end else if (e) begin
            m_err = 1'b0;
            if (u) begin
                m_tc = (m_q == M - 1);
                m_q  = (m_q + 1) % M;
            end else begin
                m_tc = (m_q == 0);
                m_q  = (m_q + M - 1) % M;
            end
        end else begin
            m_tc  = 1'b0;
            m_err = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".q"},        int'(bus.q),        m_q);
        check({tag, ".qbar"},     int'(bus.qbar),     (~m_q) & 15);
        check({tag, ".tc"},       int'(bus.tc),       int'(m_tc));
        check({tag, ".load_err"}, int'(bus.load_err), int'(m_err));
`ifdef JKCNT_GRAY_OUT_EN
        check({tag, ".gray"},     int'(bus.gray),     m_q ^ (m_q >> 1));
`endif
    endtask

    // Drive at the falling edge, let one rising edge pass, sample at the next falling edge.
    task automatic step(input logic e, input logic u, input logic l, input logic [3:0] d,
                        input string tag);
        bus.en    = e;
        bus.up_dn = u;
        bus.load  = l;
        bus.din   = d;
        @(posedge clk);
        model_edge(e, u, l, int'(d));
        @(negedge clk);
        check_model(tag);
    endtask

    vec_t tbl[$];

    initial begin
        bus.en = 1'b0;   bus.up_dn = 1'b1;   bus.load = 1'b0;   bus.din = '0;
        bus16.en = 1'b0; bus16.up_dn = 1'b1; bus16.load = 1'b0; bus16.din = '0;

        tbl.push_back('{1'b0, 1'b1, 1'b1, 4'd8,  8, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  9, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 4'd1,  1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'd0,  0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'd0,  9, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'd0,  8, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 4'd12, 0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 4'd5,  5, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 4'd10, 0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 4'd9,  9, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 4'd3,  3, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd0,  3, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 4'd0,  3, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd0,  3, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 4'd0,  3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  4, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'd0,  3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  4, 1'b0, 1'b0});

        // Reset values, held across several edges with enable asserted.
        bus.en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_reset();
        check_model("reset");

        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0, 4'd0, "first_edge");
        check("first_edge_q_is_1", int'(bus.q), 1);

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].up_dn, tbl[i].load, tbl[i].din, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.exp_q", i),   int'(bus.q),        tbl[i].exp_q);
            check($sformatf("tbl%0d.exp_tc", i),  int'(bus.tc),       int'(tbl[i].exp_tc));
            check($sformatf("tbl%0d.exp_err", i), int'(bus.load_err), int'(tbl[i].exp_err));
        end

        // Asynchronous clear in mid-cycle while tc is high and a count is pending.
        step(1'b0, 1'b1, 1'b1, 4'd9, "pre_wrap");
        step(1'b1, 1'b1, 1'b0, 4'd0, "wrap_before_rst");
        check("wrap_tc_high", int'(bus.tc), 1);
        bus.en = 1'b1;
        bus.load = 1'b1;
        bus.din = 4'd7;
        #2 rst = 1'b0;
        #1;
        check("async_q",    int'(bus.q),    0);
        check("async_qbar", int'(bus.qbar), 15);
        check("async_tc",   int'(bus.tc),   0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_model("held_reset");
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0, 4'd0, "after_release");

        // Randomized traffic against the arithmetic model.
        for (int i = 0; i < 400; i++) begin
            logic e, u, l;
            logic [3:0] d;
            e = 1'($urandom_range(0, 3) != 0);
            u = 1'($urandom_range(0, 1));
            l = 1'($urandom_range(0, 7) == 0);
            d = 4'($urandom_range(0, 15));
            step(e, u, l, d, $sformatf("rnd%0d", i));
        end

        // Full-range modulus: 15 -> 0 must wrap and pulse tc.
        bus.en = 1'b0;
        bus.load = 1'b0;
        bus16.load = 1'b1;
        bus16.din = 4'd15;
        @(posedge clk);
        @(negedge clk);
        check("m16_load_q",   int'(bus16.q),        15);
        check("m16_load_err", int'(bus16.load_err), 0);
`ifdef JKCNT_GRAY_OUT_EN
        check("m16_gray15",   int'(bus16.gray),     8);
`endif
        bus16.load = 1'b0;
        bus16.en = 1'b1;
        bus16.up_dn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("m16_wrap_q",  int'(bus16.q),  0);
        check("m16_wrap_tc", int'(bus16.tc), 1);
`ifdef JKCNT_GRAY_OUT_EN
        check("m16_gray0",   int'(bus16.gray), 0);
`endif
        for (int i = 1; i < 18; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("m16_q%0d", i),  int'(bus16.q),  i % 16);
            check($sformatf("m16_tc%0d", i), int'(bus16.tc), int'(i == 16));
`ifdef JKCNT_GRAY_OUT_EN
            check($sformatf("m16_gray%0d", i), int'(bus16.gray), (i % 16) ^ ((i % 16) >> 1));
`endif
        end
        bus16.en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter built from a bank of JK flip-flop cells. It sits directly downstream of the single JK flip-flop stage.
- Per-bit J/K drive logic converts the desired next count into J/K excitations.
- Outputs feed display/decode logic and cascade to further counter stages through a terminal-count pulse.

Parameters:
- WIDTH, 4, number of count bits / JK cells.
- MODULO, 10, count range 0..MODULO-1; legal range 2..2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset, 1 = run).
- en  input  1  count enable.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load request.
- din  input  WIDTH  parallel load value.
- q  output  WIDTH  current count.
- qbar  output  WIDTH  bitwise complement of q.
- tc  output  1  registered terminal-count pulse.
- load_err  output  1  registered pulse for an illegal load value.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values: while rst=0, q=0, qbar=all ones, tc=0, load_err=0, independent of clk. The first count can occur on the first rising edge after rst rises.
- Priority per rising edge: load > en > hold.
- Load, legal value: if load=1 and din<MODULO, then q<=din and load_err<=0.
- Load, illegal value: if load=1 and din>=MODULO, then q<=0 and load_err<=1 for exactly one cycle.
- Load and terminal count: tc<=0 on any load edge, even when en=1.
- Count up (en=1, load=0, up_dn=1): q<=q+1; at q=MODULO-1 it wraps to 0 and tc<=1.
- Count down (en=1, load=0, up_dn=0): q<=q-1; at q=0 it wraps to MODULO-1 and tc<=1.
- Hold (en=0, load=0): q holds; tc<=0; load_err<=0.
- tc timing: tc is high for the single cycle following the wrap edge. It coincides with q showing the wrapped value, so latency is 1 cycle from the wrap decision.
- Consecutive wraps: back-to-back wraps (MODULO=2, continuous count) keep tc high on consecutive cycles.
- Direction change: a change of up_dn takes effect on the next edge; there is no glitch state.
- Storage: every count bit is a JK cell.
  - Next-state N is computed combinationally.
  - Per bit: J_i = ~q_i & N_i, K_i = q_i & ~N_i.
  - When a bit holds, J=K=0. The J=K=1 toggle is never driven; excitation is set/reset only.
- Arithmetic: performed at WIDTH+1 bits so that MODULO=2**WIDTH wraps correctly.
- Output derivation: qbar is the JK cell complement outputs, never separately registered.
- Reset mid-operation: asynchronous clear overrides a pending load or count. The next edge after reset release evaluates inputs normally.

Optional Feature:
- Macro: JKCNT_GRAY_OUT_EN.
- Defined:
  - Adds output port gray [WIDTH-1:0], a registered reflected-Gray encoding of the next count. It updates on the same edge as q, so gray always equals q ^ (q>>1).
  - gray resets to 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package jk_pkg:
  - localparam helpers for the count width: CNT_W = WIDTH+1.
  - An enum dir_t {DIR_DOWN=0, DIR_UP=1}.
  - Function jk_excite(q_bit, n_bit) returning {j,k}.
- Sub-module jk_cell:
  - One JK flip-flop with clk and active-low async rst, outputs q/qbar.
  - Instantiated WIDTH times via generate.
- The top holds next-state logic, load check, and the tc/load_err registers.

Test Plan (WIDTH=4, MODULO=10 unless noted):
- Reset: rst=0 asynchronously mid-cycle with en=1 -> q=0, qbar=4'hF, tc=0 immediately; after release, en=1, up_dn=1 -> q=1 after the first edge.
- Up wrap: load 8, then en=1, up_dn=1 for 3 edges -> q=9,0,1; tc=1 only in the cycle q=0.
- Down wrap: load 1, then en=1, up_dn=0 for 3 edges -> q=0,9,8; tc=1 only in the cycle q=9.
- Load priority and error:
  - load=1, din=12, en=1 -> q=0, load_err=1 for one cycle, tc=0.
  - load=1, din=5 -> q=5, load_err=0.
- Hold and direction change: en=0 for 4 edges at q=3 -> q stays 3, tc=0; then up_dn toggles each edge with en=1 -> q=4,3,4.
- Full-range wrap: MODULO=16, WIDTH=4, load 15, count up -> q=0, tc=1. With JKCNT_GRAY_OUT_EN defined, gray tracks q^(q>>1) on every edge (q=15 -> gray=4'h8).
